// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - MEM/WB bundle, decode read ports and WB outputs of writeback_regfile
//
// Signals:
//   MEM/WB bundle : reg_write, result_src, alu_result, read_data, load_type,
//                   rd, pc_plus, pc_target, instr_valid
//   decode reads  : rs1_addr, rs2_addr -> rs1_data, rs2_data
//   WB outputs    : result_w, rd_w, reg_write_w, retire_count
// Modports:
//   master - pipeline side (drives the bundle and read addresses)
//   slave  - writeback_regfile side
interface writeback_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic              reg_write;
    logic [1:0]        result_src;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [2:0]        load_type;
    logic [4:0]        rd;
    logic [XLEN-1:0]   pc_plus;
    logic [XLEN-1:0]   pc_target;
    logic              instr_valid;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   result_w;
    logic [4:0]        rd_w;
    logic              reg_write_w;
    logic [CNT_W-1:0]  retire_count;

    modport master (
        output reg_write, result_src, alu_result, read_data, load_type, rd,
               pc_plus, pc_target, instr_valid, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, result_w, rd_w, reg_write_w, retire_count
    );

    modport slave (
        input  reg_write, result_src, alu_result, read_data, load_type, rd,
               pc_plus, pc_target, instr_valid, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, result_w, rd_w, reg_write_w, retire_count
    );
endinterface

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback stage: result select, load format, 32x32 regfile, retire counter
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset (clears x1..x31 and retire_count)
//   wb     - writeback_regfile_if.slave: MEM/WB bundle in, decode reads,
//            forwarded result_w / rd_w / reg_write_w, retire_count out
// Build option:
//   WB_REGFILE_BYPASS_EN - when defined, a read of the register being
//   committed this cycle returns result_w (write-through); otherwise it
//   returns the pre-commit array contents.
module writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    writeback_regfile_if.slave wb
);

    localparam logic [1:0] SRC_ALU    = 2'b00;
    localparam logic [1:0] SRC_LOAD   = 2'b01;
    localparam logic [1:0] SRC_PCPLUS = 2'b10;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Entry 0 is never written and is cleared on reset, so it always reads 0.
    logic [XLEN-1:0]  regs [NREGS];
    logic [CNT_W-1:0] retire_q;

    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [XLEN-1:0]  load_fmt;
    logic [XLEN-1:0]  result;
    logic             commit;
    logic [XLEN-1:0]  rs1_arr;
    logic [XLEN-1:0]  rs2_arr;

    // Lane extraction: byte from addr[1:0], half from addr[1] only, so a
    // misaligned halfword simply picks the half containing addr[1].
    always_comb begin
        byte_lane = wb.read_data[7:0];
        case (wb.alu_result[1:0])
            2'd0:    byte_lane = wb.read_data[7:0];
            2'd1:    byte_lane = wb.read_data[15:8];
            2'd2:    byte_lane = wb.read_data[23:16];
            default: byte_lane = wb.read_data[31:24];
        endcase
        half_lane = wb.alu_result[1] ? wb.read_data[31:16] : wb.read_data[15:0];
    end

    always_comb begin
        load_fmt = wb.read_data;
        case (wb.load_type)
            LD_LB:   load_fmt = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            LD_LH:   load_fmt = {{(XLEN-16){half_lane[15]}}, half_lane};
            LD_LW:   load_fmt = wb.read_data;
            LD_LBU:  load_fmt = {{(XLEN-8){1'b0}}, byte_lane};
            LD_LHU:  load_fmt = {{(XLEN-16){1'b0}}, half_lane};
            default: load_fmt = wb.read_data;
        endcase
    end

    always_comb begin
        result = wb.alu_result;
        case (wb.result_src)
            SRC_ALU:    result = wb.alu_result;
            SRC_LOAD:   result = load_fmt;
            SRC_PCPLUS: result = wb.pc_plus;
            default:    result = wb.pc_target;
        endcase
    end

    assign commit         = wb.reg_write && (wb.rd != 5'd0);
    assign wb.result_w    = result;
    assign wb.rd_w        = wb.rd;
    assign wb.reg_write_w = commit;
    assign wb.retire_count = retire_q;

    // Register array: reset wins over a commit in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb.rd] <= result;
        end
    end

    // Retire counter counts every real instruction, writing or not; it
    // wraps naturally at the top of its width.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
        end else if (wb.instr_valid) begin
            retire_q <= retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        rs1_arr = (wb.rs1_addr == 5'd0) ? '0 : regs[wb.rs1_addr];
        rs2_arr = (wb.rs2_addr == 5'd0) ? '0 : regs[wb.rs2_addr];
    end

`ifdef WB_REGFILE_BYPASS_EN
    // Write-through so decode sees the committing value without a stall;
    // disabled during reset because that commit is being aborted.
    assign wb.rs1_data = (commit && !reset && (wb.rs1_addr == wb.rd)) ? result : rs1_arr;
    assign wb.rs2_data = (commit && !reset && (wb.rs2_addr == wb.rd)) ? result : rs2_arr;
`else
    assign wb.rs1_data = rs1_arr;
    assign wb.rs2_data = rs2_arr;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed self-checking bench for writeback_regfile
module tb_writeback_regfile;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    writeback_regfile_if #(.XLEN(32), .CNT_W(64)) wb ();
    writeback_regfile_if #(.XLEN(32), .CNT_W(4))  wbw ();

    writeback_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb.slave)
    );

    // Narrow-counter instance used to exercise the wrap from all-ones to 0.
    writeback_regfile #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut_w (
        .clk   (clk),
        .reset (reset),
        .wb    (wbw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  lt;
        logic [1:0]  addr;
        logic [31:0] exp;
        string       tag;
    } load_vec_t;

    load_vec_t lvec[8];
    logic [0:12] valid_pat;

    initial begin
        total = 0;
        bad   = 0;
        lvec[0] = '{3'b000, 2'd3, 32'hFFFFFF80, "lb_a3"};
        lvec[1] = '{3'b100, 2'd1, 32'h0000007F, "lbu_a1"};
        lvec[2] = '{3'b001, 2'd2, 32'hFFFF80FF, "lh_a2"};
        lvec[3] = '{3'b101, 2'd0, 32'h00007F01, "lhu_a0"};
        lvec[4] = '{3'b010, 2'd0, 32'h80FF7F01, "lw_a0"};
        lvec[5] = '{3'b011, 2'd2, 32'h80FF7F01, "other_full"};
        lvec[6] = '{3'b001, 2'd3, 32'hFFFF80FF, "lh_misaligned_a3"};
        lvec[7] = '{3'b101, 2'd1, 32'h00007F01, "lhu_misaligned_a1"};
        valid_pat = 13'b1101110110111;

        wb.reg_write = 1'b1; wb.result_src = 2'b00; wb.alu_result = 32'hDEAD;
        wb.read_data = '0; wb.load_type = 3'b010; wb.rd = 5'd5;
        wb.pc_plus = '0; wb.pc_target = '0; wb.instr_valid = 1'b1;
        wb.rs1_addr = 5'd5; wb.rs2_addr = 5'd0;
        wbw.reg_write = 1'b0; wbw.result_src = 2'b00; wbw.alu_result = '0;
        wbw.read_data = '0; wbw.load_type = 3'b010; wbw.rd = 5'd0;
        wbw.pc_plus = '0; wbw.pc_target = '0; wbw.instr_valid = 1'b0;
        wbw.rs1_addr = 5'd0; wbw.rs2_addr = 5'd0;
        reset = 1'b1;

        // Reset with a pending commit to x5.
        step();
        check("reset_bypass_suppressed", {32'h0, wb.rs1_data}, 64'h0);
        step();
        check("reset_x5", {32'h0, wb.rs1_data}, 64'h0);
        check("reset_retire", wb.retire_count, 64'h0);
        reset = 1'b0; wb.reg_write = 1'b0; wb.instr_valid = 1'b0;
        step();
        check("post_reset_x5", {32'h0, wb.rs1_data}, 64'h0);

        // ALU commit.
        wb.result_src = 2'b00; wb.rd = 5'd3; wb.alu_result = 32'h12345678; wb.reg_write = 1'b1;
        #1;
        check("alu_result_w", {32'h0, wb.result_w}, 64'h12345678);
        check("alu_reg_write_w", {63'h0, wb.reg_write_w}, 64'h1);
        check("alu_rd_w", {59'h0, wb.rd_w}, 64'h3);
        step();
        wb.reg_write = 1'b0; wb.rs1_addr = 5'd3;
        #1;
        check("alu_x3", {32'h0, wb.rs1_data}, 64'h12345678);

        // Write to x0 is discarded.
        wb.rd = 5'd0; wb.alu_result = 32'hFFFFFFFF; wb.reg_write = 1'b1;
        #1;
        check("x0_reg_write_w", {63'h0, wb.reg_write_w}, 64'h0);
        step();
        wb.reg_write = 1'b0; wb.rs1_addr = 5'd0; wb.rs2_addr = 5'd0;
        #1;
        check("x0_rs1", {32'h0, wb.rs1_data}, 64'h0);
        check("x0_rs2", {32'h0, wb.rs2_data}, 64'h0);

        // Load formatting.
        wb.result_src = 2'b01; wb.read_data = 32'h80FF7F01;
        for (int i = 0; i < 8; i++) begin
            wb.load_type = lvec[i].lt;
            wb.alu_result = {30'h0, lvec[i].addr};
            #1;
            check(lvec[i].tag, {32'h0, wb.result_w}, {32'h0, lvec[i].exp});
        end
        wb.load_type = 3'b000; wb.alu_result = 32'h3; wb.rd = 5'd9; wb.reg_write = 1'b1;
        step();
        wb.reg_write = 1'b0; wb.rs2_addr = 5'd9;
        #1;
        check("lb_commit_x9", {32'h0, wb.rs2_data}, 64'hFFFFFF80);

        // JAL / AUIPC select.
        wb.result_src = 2'b10; wb.pc_plus = 32'h104; wb.rd = 5'd1; wb.reg_write = 1'b1;
        step();
        wb.reg_write = 1'b0; wb.rs1_addr = 5'd1;
        #1;
        check("jal_x1", {32'h0, wb.rs1_data}, 64'h104);
        wb.result_src = 2'b11; wb.pc_target = 32'h2000;
        #1;
        check("auipc_result_w", {32'h0, wb.result_w}, 64'h2000);

        // Same-cycle read/write of x7.
        wb.result_src = 2'b00; wb.rd = 5'd7; wb.alu_result = 32'h11111111; wb.reg_write = 1'b1;
        step();
        wb.alu_result = 32'hA5A5A5A5; wb.rs1_addr = 5'd7; wb.rs2_addr = 5'd7;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check("same_cycle_rs2", {32'h0, wb.rs2_data}, 64'hA5A5A5A5);
        check("same_cycle_rs1", {32'h0, wb.rs1_data}, 64'hA5A5A5A5);
`else
        check("same_cycle_rs2", {32'h0, wb.rs2_data}, 64'h11111111);
        check("same_cycle_rs1", {32'h0, wb.rs1_data}, 64'h11111111);
`endif
        step();
        wb.reg_write = 1'b0;
        #1;
        check("next_cycle_rs2", {32'h0, wb.rs2_data}, 64'hA5A5A5A5);

        // Retire counter: 10 valid among 13 cycles.
        check("retire_before", wb.retire_count, 64'h0);
        for (int i = 0; i < 13; i++) begin
            wb.instr_valid = valid_pat[i];
            step();
        end
        wb.instr_valid = 1'b0;
        check("retire_10", wb.retire_count, 64'd10);

        // Mid-stream reset aborts an in-flight commit to x4.
        wb.rd = 5'd4; wb.alu_result = 32'h55; wb.reg_write = 1'b1; wb.instr_valid = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0; wb.reg_write = 1'b0; wb.instr_valid = 1'b0;
        wb.rs1_addr = 5'd4; wb.rs2_addr = 5'd3;
        #1;
        check("abort_x4", {32'h0, wb.rs1_data}, 64'h0);
        check("abort_x3_cleared", {32'h0, wb.rs2_data}, 64'h0);
        check("abort_retire", wb.retire_count, 64'h0);

        // Wrap on the narrow counter: 15 counts to all-ones, one more to 0.
        wbw.instr_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check("wrap_allones", {60'h0, wbw.retire_count}, 64'hF);
        step();
        wbw.instr_valid = 1'b0;
        check("wrap_zero", {60'h0, wbw.retire_count}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the registered writeback bundle and selects the final result.
- Formats load data, then commits the result into the 32x32 integer register file.
- Serves the decode stage's two combinational read ports.
- Exposes the committed result for forwarding and keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural registers (x0 hardwired zero)
- CNT_W, 64, width of retire counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- reg_write  in  1  commit enable from MEM/WB register
- result_src  in  2  00 alu_result, 01 read_data, 10 pc_plus, 11 pc_target
- alu_result  in  XLEN  ALU result / load address
- read_data  in  XLEN  raw data-memory word
- load_type  in  3  funct3 of load
- rd  in  5  destination register
- pc_plus  in  XLEN  PC+4
- pc_target  in  XLEN  branch/jump target
- instr_valid  in  1  a real (non-bubble) instruction occupies WB this cycle
- rs1_addr  in  5  decode read address 1
- rs2_addr  in  5  decode read address 2
- rs1_data  out  XLEN  read data 1
- rs2_data  out  XLEN  read data 2
- result_w  out  XLEN  selected/formatted WB result (combinational, for forwarding)
- rd_w  out  5  equals rd
- reg_write_w  out  1  reg_write AND rd!=0
- retire_count  out  CNT_W  retired instruction count

Behaviour:
- Reset is synchronous and active-high on clk.
- While reset=1 at a rising edge: all registers x1..x31 := 0, retire_count := 0, and no commit occurs even if reg_write=1.
- Reset asserted mid-stream aborts the in-flight commit; normal operation resumes on the first edge with reset=0.
- Result select (combinational):
  - 00 -> alu_result
  - 01 -> formatted load
  - 10 -> pc_plus
  - 11 -> pc_target
- Load formatting applies only for result_src=01; byte lane from alu_result[1:0], half lane from alu_result[1]:
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend half
  - 010 LW: full word
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - other: full word
- Misaligned half (alu_result[0]=1) uses alu_result[1] only; no trap.
- Commit: at rising edge, if reset=0 and reg_write=1 and rd!=0, regs[rd] := result_w. Latency is 1 cycle; the value is visible in the array the next cycle.
- rd=0: write discarded; x0 always reads 0.
- Reads are combinational: rsN_data = 0 if rsN_addr=0, else regs[rsN_addr], with bypass per the optional feature.
- Both read ports may address the same register; both return identical data.
- retire_count += 1 at each edge with instr_valid=1 and reset=0.
  - Independent of reg_write, so stores and branches count.
  - Wraps from 2^64-1 to 0 silently.
- reg_write_w and rd_w are combinational passthroughs (reg_write_w masked for rd=0).

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined:
  - When reg_write=1, rd!=0 and rsN_addr==rd in the same cycle, rsN_data returns result_w (write-through), so decode sees the committing value with no extra stall.
  - Bypass is suppressed while reset=1.
- Undefined:
  - rsN_data returns the pre-commit array contents in that cycle.
  - The hazard unit must stall decode one extra cycle for a WB-to-ID dependency.

Test Plan:
- Reset: reset=1 for 2 cycles with reg_write=1, rd=5, alu_result=0xDEAD -> x5 reads 0, retire_count=0.
- ALU commit: result_src=00, rd=3, alu_result=0x12345678, reg_write=1 -> next cycle rs1_addr=3 gives 0x12345678; same with rd=0 -> x0 stays 0, reg_write_w=0.
- Loads: read_data=0x80FF7F01:
  - LB at addr[1:0]=3 -> 0xFFFFFF80
  - LBU at addr 1 -> 0x0000007F
  - LH at addr 2 -> 0xFFFF80FF
  - LHU at addr 0 -> 0x00007F01
- JAL/AUIPC select: result_src=10, pc_plus=0x104 -> x1=0x104; result_src=11, pc_target=0x2000 -> result_w=0x2000.
- Same-cycle read/write: rd=7 writes 0xA5A5A5A5 while rs2_addr=7:
  - with WB_REGFILE_BYPASS_EN -> rs2_data=0xA5A5A5A5 that cycle
  - without -> old value, new value next cycle
- Counter: preload by driving instr_valid for 10 cycles with 3 bubbles interleaved -> retire_count=10; forced wrap check at 0xFFFFFFFFFFFFFFFF +1 -> 0.
